// File: rtl/jtdd_snd_cmd.sv
// Command FIFO from the main CPU to the sound CPU. The head byte is presented on snd_latch
// with snd_irq, and snd_irq stays low for a guaranteed gap between consecutive commands.
module jtdd_snd_cmd #(
    parameter int unsigned AW  = 2,
    parameter int unsigned GAP = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_stb,
    input  logic [7:0]    main_dout,
    input  logic          snd_rd,
    input  logic          ovf_clr,
    output logic [7:0]    snd_latch,
    output logic          snd_irq,
    output logic [AW:0]   level,
    output logic          full,
    output logic          overflow
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PW    = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_GAP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_next, rd_next, lvl_next;
    logic [7:0]    cnt;
    logic [7:0]    head;
    logic          last_rd;
    logic          rd_end, pop, push, drop, empty;

    // Pop happens on the falling edge of the read strobe so the latch stays stable during the access.
    // A pop in the same cycle frees a slot, so a push into a full FIFO is then accepted.
    always_comb begin
        empty    = (level == '0);
        rd_end   = last_rd & ~snd_rd;
        pop      = (state == ST_PRESENT) & rd_end;
        push     = wr_stb & (~full | pop);
        drop     = wr_stb & full & ~pop;
        wr_next  = wr_ptr + PW'(push);
        rd_next  = rd_ptr + PW'(pop);
        lvl_next = wr_next - rd_next;
        head     = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= main_dout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            last_rd   <= 1'b0;
            snd_latch <= 8'hFF;
            snd_irq   <= 1'b0;
            cnt       <= 8'd0;
            state     <= ST_IDLE;
        end else begin
            last_rd <= snd_rd;
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            level   <= lvl_next;
            full    <= (lvl_next == PW'(DEPTH));
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        snd_latch <= head;
                        snd_irq   <= 1'b1;
                        state     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (rd_end) begin
                        snd_irq <= 1'b0;
                        cnt     <= 8'(GAP - 1);
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Reads during the gap are spurious and ignored
                    if (cnt == 8'd0) begin
                        if (!empty) begin
                            snd_latch <= head;
                            snd_irq   <= 1'b1;
                            state     <= ST_PRESENT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/jtdd_snd_cmd.md
Name: jtdd_snd_cmd

Overview:
- Main-CPU to sound-CPU command channel; sits directly upstream of the sound subsystem.
- Main CPU writes command bytes into a small FIFO.
- The block presents the head byte on snd_latch and raises snd_irq for the sound CPU.
- It pops on the end of each sound-CPU latch read and re-arms snd_irq after a guaranteed low gap, so the sound side's edge-triggered IRQ flip-flop never misses a command.

Parameters:
- AW, 2, FIFO address width; depth = 2**AW entries.
- GAP, 8, snd_irq low time in clk cycles between consecutive commands (1..255).

Ports:
- clk  in  1  system clock, 24 MHz
- rstn  in  1  reset, asynchronous, active-low
- wr_stb  in  1  one-clk pulse: push main_dout
- main_dout  in  8  command byte from main CPU
- snd_rd  in  1  level, high while the sound CPU reads the latch (latch_cs)
- ovf_clr  in  1  one-clk pulse: clear overflow
- snd_latch  out  8  command byte presented to the sound CPU
- snd_irq  out  1  high while an unread command is presented
- level  out  AW+1  FIFO occupancy, 0..2**AW
- full  out  1  level == 2**AW
- overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (rstn low, async): FIFO empty, level=0, snd_latch=8'hFF, snd_irq=0, overflow=0, state IDLE, gap counter 0.
- All outputs are registered. No clock enable; every clk edge is active.
- Push: wr_stb high and not full -> byte written at the write pointer, which increments. Pointers wrap modulo 2**AW; level derives from the AW+1-bit pointer difference.
- Push when full: byte dropped, overflow=1, state unchanged. overflow stays set until ovf_clr or reset. If ovf_clr and a dropped push coincide, overflow=1 (set wins).
- Read-end detect: snd_rd registered once. rd_end = last_snd_rd & ~snd_rd, i.e. the falling edge. Popping at the end of the access keeps snd_latch stable during the read.
- FSM states: IDLE, PRESENT, GAP.
  - IDLE: if FIFO is non-empty, load snd_latch <= head, set snd_irq=1, go to PRESENT. With wr_stb in cycle N on an empty FIFO, the byte is stored at edge N+1 and snd_latch/snd_irq update at edge N+2.
  - PRESENT: snd_irq=1. On rd_end: pop the head (read pointer +1), snd_irq=0, counter=GAP-1, go to GAP. snd_latch keeps the popped value.
  - GAP: snd_irq=0; counter decrements each clk. At 0: if non-empty, go to PRESENT and load the next head (snd_irq rises the same edge); if empty, go to IDLE.
- rd_end in IDLE or GAP is ignored (spurious read): no pop, no state change.
- Simultaneous push and pop in one cycle: both performed, level unchanged. Pushing into a full FIFO while a pop occurs in the same cycle is accepted, with no overflow.
- Empty after pop: snd_latch holds the last command, so re-reads return the same byte, matching the original single latch.
- snd_irq low time between commands ≥ GAP clks. High time is unbounded and waits for the read.
- Reset mid-operation returns every register to its reset value immediately; there is no pending-command carryover.

Test Plan:
- Reset then idle: snd_latch=FF, snd_irq=0, level=0 -> hold 100 clks unchanged.
- Single command: wr_stb with 8'h3A at cycle 10 -> snd_latch=3A and snd_irq=1 at edge 12. Then snd_rd high for 4 clks -> snd_irq=0 one clk after snd_rd falls, level=0, snd_latch remains 3A.
- Burst 4 bytes 01,02,03,04 (AW=2) -> full=1. A fifth write of 05 -> overflow=1, level=4. Sequential reads return 01..04, with snd_irq low exactly 8 clks between them. ovf_clr -> overflow=0.
- Push coincident with pop at level=4 -> level stays 4, overflow=0, pushed byte delivered last.
- Spurious snd_rd pulse during GAP and IDLE -> no pop, level unchanged, counter unaffected.
- rstn low asynchronously mid-GAP with level=2 -> outputs immediately return to reset values; next write delivers normally.
